// File: rtl/shift_seq_ctrl_pkg.sv
// Shared types and helpers for the shift-register sequencer.
// State codes are fixed because downstream debug tooling decodes them.
package shift_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int WIDTH_DEF = 8;
  localparam int DIV_W_DEF = 8;

  // Bits needed to count 0..width inclusive.
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/shift_seq_ctrl_if.sv
// Host-side request/response bundle of the shift-register sequencer.
// The host drives master; the sequencer implements slave.
interface shift_seq_ctrl_if
  import shift_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DIV_W = DIV_W_DEF
);

  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] tx_word;
  logic [DIV_W-1:0] div;
  logic             abort;
  logic [WIDTH-1:0] rx_word;
  logic             rx_valid;
  logic             busy;

  modport master (
    output start_valid,
    output tx_word,
    output div,
    output abort,
    input  start_ready,
    input  rx_word,
    input  rx_valid,
    input  busy
  );

  modport slave (
    input  start_valid,
    input  tx_word,
    input  div,
    input  abort,
    output start_ready,
    output rx_word,
    output rx_valid,
    output busy
  );

endinterface

// File: rtl/shift_register_en.sv
// Enabled serial-in/parallel-out shift register placed beside the sequencer.
// Each enabled bit enters at the MSB, so the first bit received ends up in q[0].
module shift_register_en
  import shift_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (en) begin
      q <= {d, q[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/shift_seq_ctrl_bit_rate_div.sv
// Bit-rate divider: counts 0..div_q and flags the last count of each bit period.
// Compares for equality only, so the counter never needs to wrap.
module bit_rate_div
  import shift_seq_ctrl_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [DIV_W-1:0] div_q,
  output logic             strobe
);

  logic [DIV_W-1:0] cnt;

  assign strobe = (cnt == div_q);

  // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr || strobe) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Sequencer for an external enabled shift register: paces WIDTH shifts at a
// programmable bit rate, serialises tx_word LSB-first and captures the parallel result.
module shift_seq_ctrl
  import shift_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  shift_seq_ctrl_if.slave  bus,
  input  logic             serial_in,
  output logic             tx_out,
  output logic             sr_en,
  output logic             sr_d,
  input  logic [WIDTH-1:0] sr_q
);

  localparam int              BC_W     = cnt_w(WIDTH);
  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(WIDTH - 1);

  state_e           state;
  state_e           state_nxt;
  logic [WIDTH-1:0] tx_shadow;
  logic [DIV_W-1:0] div_q;
  logic [BC_W-1:0]  bit_cnt;
  logic [WIDTH-1:0] rx_word_q;
  logic             rx_valid_q;

  logic strobe;
  logic accept;
  logic run_abort;
  logic bit_done;
  logic div_clr;

  assign accept    = (state == IDLE) && bus.start_valid;
  assign run_abort = (state == RUN) && bus.abort;
  // An abort cycle never counts as a bit, even if it lands on the strobe.
  assign bit_done  = (state == RUN) && strobe && !bus.abort;
  assign div_clr   = (state != RUN) || bus.abort;

  bit_rate_div #(
    .DIV_W (DIV_W)
  ) u_div (
    .clk    (clk),
    .rst    (rst),
    .clr    (div_clr),
    .div_q  (div_q),
    .strobe (strobe)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: state_nxt gets its default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.start_valid) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (bus.abort) begin
          state_nxt = IDLE;
        end else if (bit_done && (bit_cnt == LAST_BIT)) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Transfer datapath: shadowed word and rate are frozen for the whole transfer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_shadow <= '0;
      div_q     <= '0;
      bit_cnt   <= '0;
    end else if (accept) begin
      tx_shadow <= bus.tx_word;
      div_q     <= bus.div;
      bit_cnt   <= '0;
    end else if (run_abort) begin
      tx_shadow <= '0;
      bit_cnt   <= '0;
    end else if (bit_done) begin
      tx_shadow <= {1'b0, tx_shadow[WIDTH-1:1]};
      bit_cnt   <= bit_cnt + BC_W'(1);
    end
  end

  // Capture happens in the single DONE cycle, after the last shift has landed in sr_q.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_word_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      rx_valid_q <= (state == DONE);
      if (state == DONE) begin
        rx_word_q <= sr_q;
      end
    end
  end

  assign tx_out          = tx_shadow[0];
  assign sr_en           = bit_done;
  assign sr_d            = serial_in;
  assign bus.start_ready = (state == IDLE);
  assign bus.busy        = (state == RUN) || (state == DONE);
  assign bus.rx_word     = rx_word_q;
  assign bus.rx_valid    = rx_valid_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Bench for shift_seq_ctrl with the external shift register attached; expected
// bit timing and words come from a cycle-count model of the transfer.
module tb_shift_seq_ctrl;
  import shift_seq_ctrl_pkg::*;

  localparam int W  = 8;
  localparam int DW = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         serial_in;
  logic         tx_out;
  logic         sr_en;
  logic         sr_d;
  logic [W-1:0] sr_q;

  int           n_checks = 0;
  int           n_fail   = 0;
  logic [W-1:0] last_rx;

  shift_seq_ctrl_if #(.WIDTH(W), .DIV_W(DW)) bus ();

  shift_seq_ctrl #(.WIDTH(W), .DIV_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .serial_in (serial_in),
    .tx_out    (tx_out),
    .sr_en     (sr_en),
    .sr_d      (sr_d),
    .sr_q      (sr_q)
  );

  shift_register_en #(.WIDTH(W)) u_sr (
    .clk (clk),
    .rst (rst),
    .en  (sr_en),
    .d   (sr_d),
    .q   (sr_q)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, got no end of test, want end of test");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag, input logic [W-1:0] exp_rx);
    n_checks++;
    if (bus.start_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s start_ready: got %b want 1", tag, bus.start_ready);
    end
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL %s busy: got %b want 0", tag, bus.busy);
    end
    n_checks++;
    if (tx_out !== 1'b0) begin
      n_fail++; $display("FAIL %s tx_out: got %b want 0", tag, tx_out);
    end
    n_checks++;
    if (sr_en !== 1'b0) begin
      n_fail++; $display("FAIL %s sr_en: got %b want 0", tag, sr_en);
    end
    n_checks++;
    if (bus.rx_valid !== 1'b0) begin
      n_fail++; $display("FAIL %s rx_valid: got %b want 0", tag, bus.rx_valid);
    end
    n_checks++;
    if (bus.rx_word !== exp_rx) begin
      n_fail++; $display("FAIL %s rx_word: got %h want %h", tag, bus.rx_word, exp_rx);
    end
  endtask

  // Present a request and clock the accept edge (e0).
  task automatic accept_xfer(input logic [W-1:0] tx, input int d, input bit hold);
    bus.tx_word     = tx;
    bus.div         = DW'(d);
    bus.start_valid = 1'b1;
    #1;
    n_checks++;
    if (bus.start_ready !== 1'b1) begin
      n_fail++; $display("FAIL accept start_ready: got %b want 1", bus.start_ready);
    end
    tick();
    if (!hold) bus.start_valid = 1'b0;
  endtask

  // Model: bit k (0-based) occupies cycles k*(d+1)+1 .. (k+1)*(d+1) after e0,
  // sr_en fires on the last of them, rx_valid follows edge N+1 with rx_word = bits.
  task automatic run_xfer(input logic [W-1:0] tx, input int d, input logic [W-1:0] bits,
                          input int abort_edge, input bit scramble);
    int   n;
    int   idx;
    logic exp_en;
    logic exp_tx;
    n = W * (d + 1);
    for (int e = 0; e <= n; e++) begin
      idx    = e / (d + 1);
      exp_tx = 1'b0;
      if (e < n) begin
        serial_in = bits[idx];
        exp_tx    = tx[idx];
      end else begin
        serial_in = 1'($urandom_range(0, 1));
      end
      if (e + 1 == abort_edge) bus.abort = 1'b1;
      if (scramble) begin
        bus.start_valid = 1'($urandom_range(0, 1));
        bus.tx_word     = W'($urandom);
        bus.div         = DW'($urandom);
      end
      #1;
      exp_en = (e < n) && (((e + 1) % (d + 1)) == 0) && (e + 1 != abort_edge);
      n_checks++;
      if (sr_en !== exp_en) begin
        n_fail++; $display("FAIL sr_en cyc%0d div%0d: got %b want %b", e + 1, d, sr_en, exp_en);
      end
      n_checks++;
      if (tx_out !== exp_tx) begin
        n_fail++; $display("FAIL tx_out cyc%0d div%0d: got %b want %b", e + 1, d, tx_out, exp_tx);
      end
      n_checks++;
      if (sr_d !== serial_in) begin
        n_fail++; $display("FAIL sr_d cyc%0d: got %b want %b", e + 1, sr_d, serial_in);
      end
      n_checks++;
      if (bus.start_ready !== 1'b0 || bus.busy !== 1'b1) begin
        n_fail++; $display("FAIL busy cyc%0d: got ready=%b busy=%b want ready=0 busy=1",
                           e + 1, bus.start_ready, bus.busy);
      end
      n_checks++;
      if (bus.rx_valid !== 1'b0 || bus.rx_word !== last_rx) begin
        n_fail++; $display("FAIL rx hold cyc%0d: got valid=%b word=%h want valid=0 word=%h",
                           e + 1, bus.rx_valid, bus.rx_word, last_rx);
      end
      if (e + 1 == abort_edge) begin
        tick();
        bus.abort = 1'b0;
        return;
      end
      tick();
    end
    if (scramble) begin
      bus.start_valid = 1'b0;
      bus.tx_word     = tx;
    end
    n_checks++;
    if (bus.rx_valid !== 1'b1) begin
      n_fail++; $display("FAIL rx_valid edge%0d: got %b want 1", n + 1, bus.rx_valid);
    end
    n_checks++;
    if (bus.rx_word !== bits) begin
      n_fail++; $display("FAIL rx_word: got %h want %h", bus.rx_word, bits);
    end
    n_checks++;
    if (bus.start_ready !== 1'b1 || bus.busy !== 1'b0 || tx_out !== 1'b0) begin
      n_fail++; $display("FAIL end state: got ready=%b busy=%b tx=%b want 1 0 0",
                         bus.start_ready, bus.busy, tx_out);
    end
    last_rx = bits;
  endtask

  task automatic test_reset();
    rst             = 1'b1;
    bus.start_valid = 1'b0;
    bus.tx_word     = '0;
    bus.div         = '0;
    bus.abort       = 1'b0;
    serial_in       = 1'b0;
    #2 rst = 1'b0;
    #1;
    last_rx = '0;
    check_idle("reset asserted", '0);
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    tick();
    check_idle("after reset", '0);
  endtask

  task automatic test_basic();
    accept_xfer(8'hA5, 0, 1'b0);
    run_xfer(8'hA5, 0, 8'h4D, 0, 1'b0);
    tick();
    n_checks++;
    if (bus.rx_valid !== 1'b0) begin
      n_fail++; $display("FAIL rx_valid pulse width: got %b want 0", bus.rx_valid);
    end
  endtask

  task automatic test_div3();
    accept_xfer(8'h01, 3, 1'b0);
    run_xfer(8'h01, 3, W'($urandom), 0, 1'b0);
    tick();
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] tx_b;
    logic [W-1:0] bits_a;
    logic [W-1:0] bits_b;
    tx_b   = W'($urandom);
    bits_a = W'($urandom);
    bits_b = W'($urandom);
    accept_xfer(8'h3C, 0, 1'b1);
    bus.tx_word = tx_b;
    run_xfer(8'h3C, 0, bits_a, 0, 1'b0);
    tick();
    bus.start_valid = 1'b0;
    run_xfer(tx_b, 0, bits_b, 0, 1'b0);
    tick();
  endtask

  task automatic test_abort();
    accept_xfer(8'hC7, 1, 1'b0);
    run_xfer(8'hC7, 1, W'($urandom), 8, 1'b0);
    check_idle("after abort", last_rx);
    for (int i = 0; i < 6; i++) begin
      tick();
      n_checks++;
      if (sr_en !== 1'b0 || bus.rx_valid !== 1'b0 || bus.busy !== 1'b0) begin
        n_fail++; $display("FAIL post-abort cyc%0d: got en=%b valid=%b busy=%b want 0 0 0",
                           i, sr_en, bus.rx_valid, bus.busy);
      end
    end
    bus.abort = 1'b1;
    accept_xfer(8'h96, 0, 1'b0);
    bus.abort = 1'b0;
    run_xfer(8'h96, 0, W'($urandom), 0, 1'b0);
    tick();
  endtask

  task automatic test_async_reset();
    accept_xfer(8'h5A, 2, 1'b0);
    repeat (5) tick();
    #2 rst = 1'b0;
    #1;
    last_rx = '0;
    check_idle("async reset", '0);
    n_checks++;
    if (sr_q !== '0) begin
      n_fail++; $display("FAIL async reset sr_q: got %h want 00", sr_q);
    end
    #2 rst = 1'b1;
    tick();
    accept_xfer(8'hFF, 0, 1'b0);
    run_xfer(8'hFF, 0, W'($urandom), 0, 1'b0);
    tick();
  endtask

  task automatic test_busy_ignore();
    accept_xfer(8'h6B, 2, 1'b0);
    run_xfer(8'h6B, 2, W'($urandom), 0, 1'b1);
    tick();
    check_idle("after busy scramble", last_rx);
  endtask

  task automatic test_random();
    logic [W-1:0] tx;
    int           d;
    for (int i = 0; i < 7; i++) begin
      tx = W'($urandom);
      d  = (i == 6) ? 255 : int'($urandom_range(0, 4));
      accept_xfer(tx, d, 1'b0);
      run_xfer(tx, d, W'($urandom), 0, 1'b0);
      if ($urandom_range(0, 1) == 1) tick();
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_div3();
    test_back_to_back();
    test_abort();
    test_async_reset();
    test_busy_ignore();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
